// File: rtl/tnn_pkg.sv
// Shared widths, types and defaults for the TNN input front end.
package tnn_pkg;

    localparam int unsigned FEAT_N   = 6;
    localparam int unsigned IN_W     = 8;
    localparam int unsigned Q_W      = 3;
    localparam int unsigned LVL_N    = 7;
    localparam int unsigned THR_STEP = 32;
    localparam int unsigned IDX_W    = 3;
    localparam int unsigned CNT_W    = 16;

    typedef logic [Q_W-1:0]   q_code_t;
    typedef logic [IDX_W-1:0] feat_idx_t;

    // One quantized frame, feature 0 in field a through feature 5 in field f.
    typedef struct packed {
        q_code_t a;
        q_code_t b;
        q_code_t c;
        q_code_t d;
        q_code_t e;
        q_code_t f;
    } q_frame_t;

    // Reset value of threshold level lvl (1..7): evenly spaced steps.
    function automatic logic [IN_W-1:0] default_thr(input int unsigned lvl);
        return IN_W'(THR_STEP * lvl);
    endfunction

endpackage

// File: rtl/tnn_input_quantizer_if.sv
// Raw beat stream in, quantized frame out.
interface tnn_input_quantizer_if #(
    parameter int unsigned IN_W = 8,
    parameter int unsigned Q_W  = 3
) ();

    logic            s_valid;
    logic            s_ready;
    logic [IN_W-1:0] s_data;
    logic            s_last;

    logic            m_valid;
    logic            m_ready;
    logic [Q_W-1:0]  m_a;
    logic [Q_W-1:0]  m_b;
    logic [Q_W-1:0]  m_c;
    logic [Q_W-1:0]  m_d;
    logic [Q_W-1:0]  m_e;
    logic [Q_W-1:0]  m_f;

    // Environment view: produces raw beats, consumes frames.
    modport master (
        output s_valid, s_data, s_last, m_ready,
        input  s_ready, m_valid, m_a, m_b, m_c, m_d, m_e, m_f
    );

    // Quantizer view.
    modport slave (
        input  s_valid, s_data, s_last, m_ready,
        output s_ready, m_valid, m_a, m_b, m_c, m_d, m_e, m_f
    );

endinterface

// File: rtl/tnn_thermo_quant.sv
// Thermometer quantizer: counts how many thresholds the value meets or exceeds.
module tnn_thermo_quant #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned LVL_N = 7
) (
    input  logic [IN_W-1:0]            value,
    input  logic [LVL_N-1:0][IN_W-1:0] thr,
    output logic [2:0]                 count
);

    // Plain population count, so non-monotonic tables still give 0..7.
    always_comb begin
        count = 3'd0;
        for (int unsigned k = 0; k < LVL_N; k++) begin
            if (value >= thr[k]) begin
                count = count + 3'd1;
            end
        end
    end

endmodule

// File: rtl/tnn_input_quantizer.sv
// Quantizes a six-beat raw feature frame into six thermometer codes for the neuron array.
module tnn_input_quantizer #(
    parameter int unsigned FEAT_N = tnn_pkg::FEAT_N,
    parameter int unsigned IN_W   = tnn_pkg::IN_W,
    parameter int unsigned Q_W    = tnn_pkg::Q_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [2:0]               cfg_feat,
    input  logic [2:0]               cfg_lvl,
    input  logic [IN_W-1:0]          cfg_thr,
    tnn_input_quantizer_if.slave     bus,
    output logic                     err_frame,
    output logic [tnn_pkg::CNT_W-1:0] frame_cnt
);

    import tnn_pkg::*;

    localparam feat_idx_t LAST_IDX = feat_idx_t'(FEAT_N - 1);

    logic [IN_W-1:0]            thr_q [FEAT_N][LVL_N];
    logic [LVL_N-1:0][IN_W-1:0] thr_sel;
    logic [2:0]                 code_raw;
    q_code_t                    code;
    logic                       cfg_ok;
    logic                       accept;
    logic                       handshake;

    feat_idx_t                  idx_q, idx_d;
    q_code_t                    slot_q [FEAT_N];
    q_code_t                    slot_d [FEAT_N];
    q_frame_t                   out_q, out_d;
    logic                       m_valid_q, m_valid_d;
    logic                       s_ready_q, s_ready_d;
    logic                       err_q, err_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;

    assign cfg_ok    = cfg_we && (32'(cfg_feat) < FEAT_N) && (cfg_lvl != 3'd0);
    assign accept    = bus.s_valid && s_ready_q;
    assign handshake = m_valid_q && bus.m_ready;

    // Threshold table; level n lives at column n-1.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned f = 0; f < FEAT_N; f++) begin
                for (int unsigned k = 0; k < LVL_N; k++) begin
                    thr_q[f][k] <= IN_W'(default_thr(k + 1));
                end
            end
        end else if (cfg_ok) begin
            thr_q[cfg_feat][cfg_lvl - 3'd1] <= cfg_thr;
        end
    end

    // Row of thresholds for the feature currently being received.
    always_comb begin
        thr_sel = '0;
        for (int unsigned k = 0; k < LVL_N; k++) begin
            thr_sel[k] = thr_q[idx_q][k];
        end
    end

    tnn_thermo_quant #(
        .IN_W  (IN_W),
        .LVL_N (LVL_N)
    ) u_quant (
        .value (bus.s_data),
        .thr   (thr_sel),
        .count (code_raw)
    );

    assign code = q_code_t'(code_raw);

    // Frame assembly, output hold and framing checks.
    always_comb begin
        idx_d     = idx_q;
        slot_d    = slot_q;
        out_d     = out_q;
        m_valid_d = m_valid_q && !bus.m_ready;
        err_d     = 1'b0;
        cnt_d     = cnt_q + CNT_W'(handshake);

        if (accept) begin
            slot_d[idx_q] = code;
            if (idx_q == LAST_IDX) begin
                out_d.a   = slot_d[0];
                out_d.b   = slot_d[1];
                out_d.c   = slot_d[2];
                out_d.d   = slot_d[3];
                out_d.e   = slot_d[4];
                out_d.f   = slot_d[5];
                m_valid_d = 1'b1;
                idx_d     = '0;
                err_d     = !bus.s_last;
            end else if (bus.s_last) begin
                // Short frame: drop what was collected and resync.
                idx_d = '0;
                err_d = 1'b1;
            end else begin
                idx_d = idx_q + feat_idx_t'(1);
            end
        end

        // Stall the final beat only while the previous frame is still held.
        s_ready_d = !((idx_d == LAST_IDX) && m_valid_d);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            out_q     <= '0;
            m_valid_q <= 1'b0;
            s_ready_q <= 1'b1;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            for (int unsigned f = 0; f < FEAT_N; f++) begin
                slot_q[f] <= '0;
            end
        end else begin
            idx_q     <= idx_d;
            out_q     <= out_d;
            m_valid_q <= m_valid_d;
            s_ready_q <= s_ready_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            slot_q    <= slot_d;
        end
    end

    assign bus.s_ready = s_ready_q;
    assign bus.m_valid = m_valid_q;
    assign bus.m_a     = Q_W'(out_q.a);
    assign bus.m_b     = Q_W'(out_q.b);
    assign bus.m_c     = Q_W'(out_q.c);
    assign bus.m_d     = Q_W'(out_q.d);
    assign bus.m_e     = Q_W'(out_q.e);
    assign bus.m_f     = Q_W'(out_q.f);
    assign err_frame   = err_q;
    assign frame_cnt   = cnt_q;

endmodule

// File: tb/tb_tnn_input_quantizer.sv
// Self-checking bench for tnn_input_quantizer: vector table plus scoreboarded corner sequences.
module tb_tnn_input_quantizer;

    import tnn_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [2:0]  cfg_feat;
    logic [2:0]  cfg_lvl;
    logic [7:0]  cfg_thr;
    logic        err_frame;
    logic [15:0] frame_cnt;

    tnn_input_quantizer_if #(.IN_W(IN_W), .Q_W(Q_W)) bus ();

    tnn_input_quantizer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_we    (cfg_we),
        .cfg_feat  (cfg_feat),
        .cfg_lvl   (cfg_lvl),
        .cfg_thr   (cfg_thr),
        .bus       (bus),
        .err_frame (err_frame),
        .frame_cnt (frame_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d [6];
        q_frame_t   exp;
    } vec_t;

    vec_t       vecs [4];
    q_frame_t   sbq [$];
    logic [7:0] mthr [6][7];
    int         total = 0;
    int         bad = 0;
    int         err_seen = 0;
    int         pops = 0;
    int         exp_frames = 0;
    q_frame_t   mon_got;
    q_frame_t   mon_exp;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int f = 0; f < 6; f++)
            for (int k = 0; k < 7; k++)
                mthr[f][k] = 8'(32 * (k + 1));
    endtask

    function automatic q_code_t model_q(input int f, input logic [7:0] v);
        int c = 0;
        for (int k = 0; k < 7; k++)
            if (v >= mthr[f][k]) c++;
        return q_code_t'(c);
    endfunction

    task automatic model_write(input logic [2:0] f, input logic [2:0] l, input logic [7:0] t);
        if (f < 3'd6 && l != 3'd0) mthr[f][l - 3'd1] = t;
    endtask

    task automatic push_exp(input q_frame_t e);
        sbq.push_back(e);
        exp_frames++;
    endtask

    // Output monitor: every delivered frame is matched against the scoreboard.
    always @(negedge clk) begin
        if (err_frame) err_seen++;
        if (bus.m_valid && bus.m_ready) begin
            pops++;
            mon_got = {bus.m_a, bus.m_b, bus.m_c, bus.m_d, bus.m_e, bus.m_f};
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_frame got=%0h exp=none at %0t", mon_got, $time);
            end else begin
                mon_exp = sbq.pop_front();
                check("frame_codes", 32'(mon_got), 32'(mon_exp));
            end
        end
    end

    task automatic cfg_write(input logic [2:0] f, input logic [2:0] l, input logic [7:0] t);
        cfg_we = 1'b1; cfg_feat = f; cfg_lvl = l; cfg_thr = t;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        model_write(f, l, t);
    endtask

    task automatic send_beat(input logic [7:0] d, input logic last);
        bit done = 0;
        bus.s_valid = 1'b1; bus.s_data = d; bus.s_last = last;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL beat_accept_timeout got=stalled exp=accepted at %0t", $time);
        end
        bus.s_valid = 1'b0; bus.s_last = 1'b0; cfg_we = 1'b0;
    endtask

    // Six beats; optionally a cfg write rides along with beat wr_beat.
    task automatic send_beats(input logic [7:0] d [6], input bit last_ok, input int wr_beat,
                              input logic [2:0] wf, input logic [2:0] wl, input logic [7:0] wt);
        for (int b = 0; b < 6; b++) begin
            if (b == wr_beat) begin
                cfg_we = 1'b1; cfg_feat = wf; cfg_lvl = wl; cfg_thr = wt;
            end
            send_beat(d[b], (b == 5) && last_ok);
        end
        if (wr_beat >= 0) model_write(wf, wl, wt);
    endtask

    task automatic send_frame(input logic [7:0] d [6], input bit last_ok, input int wr_beat,
                              input logic [2:0] wf, input logic [2:0] wl, input logic [7:0] wt);
        q_frame_t e;
        e.a = model_q(0, d[0]); e.b = model_q(1, d[1]); e.c = model_q(2, d[2]);
        e.d = model_q(3, d[3]); e.e = model_q(4, d[4]); e.f = model_q(5, d[5]);
        push_exp(e);
        send_beats(d, last_ok, wr_beat, wf, wl, wt);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sbq.size() != 0; i++) @(posedge clk);
        #1;
        check(name, 32'(sbq.size()), 32'd0);
    endtask

    logic [7:0] fr [6];
    int         e0;
    int         p0;

    initial begin
        vecs[0].d = '{8'd0, 8'd31, 8'd32, 8'd100, 8'd224, 8'd255};
        vecs[0].exp = {3'd0, 3'd0, 3'd1, 3'd3, 3'd7, 3'd7};
        vecs[1].d = '{8'd63, 8'd64, 8'd95, 8'd96, 8'd191, 8'd192};
        vecs[1].exp = {3'd1, 3'd2, 3'd2, 3'd3, 3'd5, 3'd6};
        vecs[2].d = '{8'd1, 8'd33, 8'd65, 8'd97, 8'd129, 8'd161};
        vecs[2].exp = {3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5};
        vecs[3].d = '{8'd255, 8'd223, 8'd128, 8'd127, 8'd0, 8'd160};
        vecs[3].exp = {3'd7, 3'd6, 3'd4, 3'd3, 3'd0, 3'd5};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_feat = '0; cfg_lvl = '0; cfg_thr = '0;
        bus.s_valid = 1'b0; bus.s_data = '0; bus.s_last = 1'b0; bus.m_ready = 1'b1;
        model_reset();

        repeat (3) @(posedge clk);
        #1;
        check("rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("rst_err_frame", 32'(err_frame), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("rst_m_codes", 32'({bus.m_a, bus.m_b, bus.m_c, bus.m_d, bus.m_e, bus.m_f}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("s_ready_after_reset", 32'(bus.s_ready), 32'd1);

        // Default-table vectors.
        for (int i = 0; i < 4; i++) begin
            push_exp(vecs[i].exp);
            send_beats(vecs[i].d, 1'b1, -1, 3'd0, 3'd0, 8'd0);
            if (i == 0) begin
                check("latency_m_valid", 32'(bus.m_valid), 32'd1);
                check("latency_m_c", 32'(bus.m_c), 32'd1);
                @(posedge clk); #1;
                check("first_frame_cnt", 32'(frame_cnt), 32'd1);
            end
        end
        drain("table_drain");
        check("table_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // Writes with level 0 or feature out of range are dropped.
        cfg_write(3'd6, 3'd1, 8'd0);
        cfg_write(3'd0, 3'd0, 8'd0);
        cfg_write(3'd7, 3'd3, 8'd0);
        push_exp(vecs[0].exp);
        send_beats(vecs[0].d, 1'b1, -1, 3'd0, 3'd0, 8'd0);
        drain("ignored_wr_drain");

        // Threshold write before the frame takes effect; write in the acceptance cycle does not.
        fr = '{8'd50, 8'd50, 8'd10, 8'd50, 8'd50, 8'd50};
        cfg_write(3'd2, 3'd1, 8'd10);
        send_frame(fr, 1'b1, -1, 3'd0, 3'd0, 8'd0);
        check("m_c_after_write", 32'(bus.m_c), 32'd1);
        cfg_write(3'd2, 3'd1, 8'd32);
        send_frame(fr, 1'b1, 2, 3'd2, 3'd1, 8'd10);
        check("m_c_same_cycle_write", 32'(bus.m_c), 32'd0);
        send_frame(fr, 1'b1, -1, 3'd0, 3'd0, 8'd0);
        check("m_c_write_visible_later", 32'(bus.m_c), 32'd1);
        cfg_write(3'd2, 3'd1, 8'd32);
        drain("cfg_drain");

        // Sixth beat without s_last: error pulse, frame still delivered.
        e0 = err_seen;
        send_frame(vecs[2].d, 1'b0, -1, 3'd0, 3'd0, 8'd0);
        repeat (2) @(posedge clk);
        #1;
        check("missing_last_err", 32'(err_seen - e0), 32'd1);
        drain("missing_last_drain");

        // Early s_last: one error pulse, partial frame discarded, resync on next beat.
        e0 = err_seen;
        p0 = pops;
        send_beat(8'd200, 1'b0);
        send_beat(8'd200, 1'b0);
        send_beat(8'd200, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("short_frame_err", 32'(err_seen - e0), 32'd1);
        check("short_frame_no_output", 32'(pops - p0), 32'd0);
        push_exp(vecs[1].exp);
        send_beats(vecs[1].d, 1'b1, -1, 3'd0, 3'd0, 8'd0);
        drain("resync_drain");
        check("frame_cnt_mid", 32'(frame_cnt), 32'(exp_frames));

        // Back-pressure: second frame's last beat stalls while the first is held.
        bus.m_ready = 1'b0;
        push_exp(vecs[2].exp);
        send_beats(vecs[2].d, 1'b1, -1, 3'd0, 3'd0, 8'd0);
        push_exp(vecs[3].exp);
        for (int b = 0; b < 5; b++) send_beat(vecs[3].d[b], 1'b0);
        bus.s_valid = 1'b1; bus.s_data = vecs[3].d[5]; bus.s_last = 1'b1;
        repeat (3) @(negedge clk);
        check("stall_s_ready", 32'(bus.s_ready), 32'd0);
        check("stall_m_valid", 32'(bus.m_valid), 32'd1);
        check("stall_hold_codes", 32'({bus.m_a, bus.m_b, bus.m_c, bus.m_d, bus.m_e, bus.m_f}),
              32'(vecs[2].exp));
        @(posedge clk); #1;
        bus.m_ready = 1'b1;
        send_beat(vecs[3].d[5], 1'b1);
        drain("backpressure_drain");
        @(posedge clk); #1;
        check("backpressure_frame_cnt", 32'(frame_cnt), 32'(exp_frames));

        // Reset mid-operation with a frame pending and a partial one in flight.
        cfg_write(3'd0, 3'd1, 8'd0);
        bus.m_ready = 1'b0;
        send_frame(vecs[1].d, 1'b1, -1, 3'd0, 3'd0, 8'd0);
        for (int b = 0; b < 4; b++) send_beat(vecs[0].d[b], 1'b0);
        check("pre_reset_m_valid", 32'(bus.m_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("async_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check("async_rst_s_ready", 32'(bus.s_ready), 32'd1);
        sbq.delete();
        exp_frames = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        check("post_reset_s_ready", 32'(bus.s_ready), 32'd1);
        push_exp(vecs[0].exp);
        send_beats(vecs[0].d, 1'b1, -1, 3'd0, 3'd0, 8'd0);
        check("post_reset_m_a_default_thr", 32'(bus.m_a), 32'd0);
        drain("post_reset_drain");
        @(posedge clk); #1;
        check("post_reset_frame_cnt", 32'(frame_cnt), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
